fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: DATA_WIDTH, 32, instruction width.
REQ-002 Parameter: ADDRESS_WIDTH, 32, PC/address width.
REQ-003 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-004 clk  in  1  clock; all state updates on posedge clk.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 stall  in  1  decode register not loading this edge (decode register enable = ~stall).
REQ-007 redirect  in  1  taken branch/jump from execute; flush and restart fetch.
REQ-008 redirect_pc  in  ADDRESS_WIDTH  new fetch address, valid when redirect=1.
REQ-009 imem_req  out  1  instruction memory request.
REQ-010 imem_addr  out  ADDRESS_WIDTH  request address, equal to pc_q.
REQ-011 imem_ready  in  1  memory accepts request this cycle (handshake = imem_req & imem_ready).
REQ-012 imem_rvalid  in  1  read data valid, at least 1 cycle after acceptance.
REQ-013 imem_rdata  in  DATA_WIDTH  instruction word.
REQ-014 f_instr  out  DATA_WIDTH  instruction to decode register; NOP 32'h0000_0013 when f_valid=0.
REQ-015 f_pc  out  ADDRESS_WIDTH  PC of f_instr.
REQ-016 f_pcplus4  out  ADDRESS_WIDTH  f_pc + 4, modulo 2^ADDRESS_WIDTH.
REQ-017 f_valid  out  1  instruction buffer holds a real instruction.

Function
REQ-018 Registers: pc_q (next fetch address), FSM state, one-entry buffer {ib_valid, ib_instr, ib_pc}.
REQ-019 FSM states: REQ (may issue), WAIT (one outstanding, keep), DROP (one outstanding, discard).
REQ-020 At most one outstanding memory request at any time.
REQ-021 imem_req = (state==REQ) & (~ib_valid | ~stall) & ~redirect; may deassert before acceptance.
REQ-022 On acceptance: pc_q <= pc_q + 4 (wraps), REQ -> WAIT; request PC recorded for the buffer.
REQ-023 WAIT with imem_rvalid and no redirect: buffer <= {1, imem_rdata, request PC}; WAIT -> REQ.
REQ-024 f_instr/f_pc/f_pcplus4/f_valid driven only from the buffer (registered, no combinational path from imem_rdata).
REQ-025 Consumption: ib_valid & ~stall at an edge clears ib_valid unless REQ-023 writes the buffer at that edge.
REQ-026 The issue condition in REQ-021 guarantees the buffer is empty when a response arrives; no response overwrites an unconsumed instruction.
REQ-027 Redirect (priority over stall and responses): pc_q <= {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00}; ib_valid <= 0.
REQ-028 Redirect in WAIT without rvalid -> DROP; redirect in WAIT with rvalid same cycle: data discarded, -> REQ.
REQ-029 DROP: next imem_rvalid discarded, -> REQ; redirect in DROP updates pc_q, stays DROP (or -> REQ if rvalid same cycle).
REQ-030 imem_rvalid in REQ is ignored.
REQ-031 Throughput: one instruction per 2 cycles with single-cycle memory; no further buffering.

Reset
REQ-032 rst at posedge: pc_q <= RESET_PC, state <= REQ, ib_valid <= 0, ib_instr <= NOP, ib_pc <= 0; overrides redirect and responses.
REQ-033 Outstanding request at reset is abandoned; a late imem_rvalid after reset arrives in REQ and is ignored per REQ-030.
REQ-034 While rst=1: imem_req=0, f_valid=0, f_instr=NOP, f_pc=0, f_pcplus4=4.

Structure
REQ-035 Shared package fetch_pkg: FSM state enum, NOP_INSTR constant, RESET_PC default.
REQ-036 One sub-module fetch_buf: one-entry instruction/PC buffer with write, consume and flush inputs.

Verification
REQ-037 Reset, memory always ready, 1-cycle latency, stall=0 -> addresses 0,4,8 issued; f_pc 0,4,8 each valid for 1 cycle, NOP bubble between.
REQ-038 Buffer holds 0x00500093 @ PC 0x10, stall=1 for 3 cycles -> f_* unchanged, imem_req=0; stall drops -> next request 0x14 issues.
REQ-039 Redirect to 0x200 while WAIT on 0x40 -> f_valid=0 next cycle; 0x40 response discarded; next request 0x200; f_pc=0x200.
REQ-040 Redirect to 0x103 with rvalid in the same cycle -> response dropped; next request address 0x100.
REQ-041 imem_ready low 5 cycles with request pending -> imem_addr stable, pc_q not advanced, f_valid=0.
REQ-042 rst during WAIT, late rvalid 0xDEADBEEF next cycle -> ignored; request to RESET_PC; f_instr=0x00000013 until the new response.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Holds the fetch FSM encoding and the architectural NOP.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_buf.sv
// One-entry instruction/PC buffer feeding the decode register.
// Flush beats write, write beats consume.
module fetch_buf
    import fetch_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr,
    input  logic [DATA_WIDTH-1:0]    wr_instr,
    input  logic [ADDRESS_WIDTH-1:0] wr_pc,
    input  logic                     consume,
    input  logic                     flush,
    output logic                     valid,
    output logic [DATA_WIDTH-1:0]    instr,
    output logic [ADDRESS_WIDTH-1:0] pc
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            instr <= DATA_WIDTH'(NOP_INSTR);
            pc    <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (wr) begin
            valid <= 1'b1;
            instr <= wr_instr;
            pc    <= wr_pc;
        end else if (consume) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: single outstanding request, one-entry
// output buffer, redirect flush with in-flight response discard.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC =
        ADDRESS_WIDTH'(RESET_PC_DEFAULT)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall,
    input  logic                     redirect,
    input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
    output logic                     imem_req,
    output logic [ADDRESS_WIDTH-1:0] imem_addr,
    input  logic                     imem_ready,
    input  logic                     imem_rvalid,
    input  logic [DATA_WIDTH-1:0]    imem_rdata,
    output logic [DATA_WIDTH-1:0]    f_instr,
    output logic [ADDRESS_WIDTH-1:0] f_pc,
    output logic [ADDRESS_WIDTH-1:0] f_pcplus4,
    output logic                     f_valid
);

    fetch_state_t state_q, state_d;

    logic [ADDRESS_WIDTH-1:0] pc_q;
    logic [ADDRESS_WIDTH-1:0] req_pc_q;
    logic                     accept;
    logic                     buf_wr;
    logic                     ib_valid;
    logic [DATA_WIDTH-1:0]    ib_instr;
    logic [ADDRESS_WIDTH-1:0] ib_pc;

    // Issue only when the buffer is guaranteed free by response time.
    assign imem_req = (state_q == S_REQ) & (~ib_valid | ~stall)
                    & ~redirect & ~rst;
    assign imem_addr = pc_q;
    assign accept    = imem_req & imem_ready;

    always_comb begin
        state_d = state_q;
        buf_wr  = 1'b0;
        unique case (state_q)
            S_REQ: begin
                if (accept) state_d = S_WAIT;
            end
            S_WAIT: begin
                unique case (1'b1)
                    (redirect && imem_rvalid):  state_d = S_REQ;
                    (redirect && !imem_rvalid): state_d = S_DROP;
                    (!redirect && imem_rvalid): begin
                        buf_wr  = 1'b1;
                        state_d = S_REQ;
                    end
                    default: ;
                endcase
            end
            S_DROP: begin
                if (imem_rvalid) state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_REQ;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
        end else begin
            state_q <= state_d;
            if (redirect)
                pc_q <= redirect_pc & ~ADDRESS_WIDTH'(3);
            else if (accept)
                pc_q <= pc_q + ADDRESS_WIDTH'(4);
            if (accept)
                req_pc_q <= pc_q;
        end
    end

    fetch_buf #(
        .DATA_WIDTH   (DATA_WIDTH),
        .ADDRESS_WIDTH(ADDRESS_WIDTH)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr      (buf_wr),
        .wr_instr(imem_rdata),
        .wr_pc   (req_pc_q),
        .consume (~stall),
        .flush   (redirect),
        .valid   (ib_valid),
        .instr   (ib_instr),
        .pc      (ib_pc)
    );

    assign f_valid   = ib_valid & ~rst;
    assign f_instr   = f_valid ? ib_instr : DATA_WIDTH'(NOP_INSTR);
    assign f_pc      = rst ? '0 : ib_pc;
    assign f_pcplus4 = f_pc + ADDRESS_WIDTH'(4);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: vector table, directed corner sequences
// and a random run against a queue-based reference model.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] f_instr;
    logic [31:0] f_pc;
    logic [31:0] f_pcplus4;
    logic        f_valid;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_unit #(
        .DATA_WIDTH   (32),
        .ADDRESS_WIDTH(32),
        .RESET_PC     (32'h0000_0000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .f_instr    (f_instr),
        .f_pc       (f_pc),
        .f_pcplus4  (f_pcplus4),
        .f_valid    (f_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: outstanding requests kept as a queue
    typedef struct {
        logic [31:0] addr;
        logic        keep;
    } pend_t;

    typedef struct {
        logic [31:0] addr;
        int          wt;
    } mem_t;

    pend_t       m_pend[$];
    mem_t        mem_q[$];
    logic        m_bv = 1'b0;
    logic [31:0] m_bi = NOP;
    logic [31:0] m_bp = 32'h0;
    logic [31:0] m_pc = 32'h0;
    logic        mem_on = 1'b0;
    logic        rv_from_mem = 1'b0;

    function automatic logic m_req();
        return (m_pend.size() == 0) && (!m_bv || !stall)
            && !redirect && !rst;
    endfunction

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return {a[29:0], 2'b11} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        logic        acc;
        logic [31:0] apc;
        logic        wr;
        pend_t       e;
        acc = m_req() && imem_ready;
        apc = m_pc;
        wr  = 1'b0;
        e   = '{32'h0, 1'b0};
        @(posedge clk);
        if (rst) begin
            m_bv = 1'b0;
            m_bi = NOP;
            m_bp = 32'h0;
            m_pc = 32'h0;
            m_pend.delete();
        end else begin
            if (imem_rvalid && m_pend.size() > 0) begin
                e  = m_pend.pop_front();
                wr = e.keep && !redirect;
            end
            if (redirect) begin
                foreach (m_pend[i]) m_pend[i].keep = 1'b0;
                m_bv = 1'b0;
                m_pc = {redirect_pc[31:2], 2'b00};
            end else if (wr) begin
                m_bv = 1'b1;
                m_bi = imem_rdata;
                m_bp = e.addr;
            end else if (m_bv && !stall) begin
                m_bv = 1'b0;
            end
            if (acc) begin
                m_pend.push_back('{apc, 1'b1});
                m_pc = apc + 32'd4;
            end
        end
        if (mem_on) begin
            if (rv_from_mem) void'(mem_q.pop_front());
            foreach (mem_q[i]) if (mem_q[i].wt > 0) mem_q[i].wt--;
            if (acc && !rst)
                mem_q.push_back('{apc, int'($urandom_range(0, 2))});
        end
        #1;
    endtask

    task automatic set(input logic s, input logic r,
                       input logic [31:0] rp, input logic rdy,
                       input logic rv, input logic [31:0] rd);
        stall       = s;
        redirect    = r;
        redirect_pc = rp;
        imem_ready  = rdy;
        imem_rvalid = rv;
        imem_rdata  = rd;
        #1;
    endtask

    task automatic check_model();
        chk("rnd_req", 32'(imem_req), 32'(m_req()));
        chk("rnd_addr", imem_addr, m_pc);
        chk("rnd_valid", 32'(f_valid), 32'(m_bv));
        chk("rnd_instr", f_instr, m_bv ? m_bi : NOP);
        if (m_bv) begin
            chk("rnd_pc", f_pc, m_bp);
            chk("rnd_pc4", f_pcplus4, m_bp + 32'd4);
        end
    endtask

    task automatic chk_reset_outs(input string nm);
        chk({nm, "_req"}, 32'(imem_req), 32'h0);
        chk({nm, "_valid"}, 32'(f_valid), 32'h0);
        chk({nm, "_instr"}, f_instr, NOP);
        chk({nm, "_pc"}, f_pc, 32'h0);
        chk({nm, "_pc4"}, f_pcplus4, 32'h4);
    endtask

    typedef struct {
        logic        rv;
        logic [31:0] rd;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
    } vec_t;

    vec_t tbl[7];

    initial begin
        tbl[0] = '{1'b0, 32'h0,         1'b1, 32'h0, 1'b0, NOP,           32'h0};
        tbl[1] = '{1'b1, 32'h0010_0093, 1'b0, 32'h4, 1'b0, NOP,           32'h0};
        tbl[2] = '{1'b0, 32'h0,         1'b1, 32'h4, 1'b1, 32'h0010_0093, 32'h0};
        tbl[3] = '{1'b1, 32'h0020_0113, 1'b0, 32'h8, 1'b0, NOP,           32'h0};
        tbl[4] = '{1'b0, 32'h0,         1'b1, 32'h8, 1'b1, 32'h0020_0113, 32'h4};
        tbl[5] = '{1'b1, 32'h0030_0193, 1'b0, 32'hC, 1'b0, NOP,           32'h0};
        tbl[6] = '{1'b0, 32'h0,         1'b1, 32'hC, 1'b1, 32'h0030_0193, 32'h8};

        rst = 1'b1;
        set(0, 0, 0, 1, 0, 0);
        chk_reset_outs("rst0");
        tick();
        tick();
        chk_reset_outs("rst1");
        rst = 1'b0;

        // Back-to-back fetch with single-cycle memory
        for (int i = 0; i < 7; i++) begin
            set(0, 0, 0, 1, tbl[i].rv, tbl[i].rd);
            chk($sformatf("vec%0d_req", i), 32'(imem_req), 32'(tbl[i].req));
            chk($sformatf("vec%0d_addr", i), imem_addr, tbl[i].addr);
            chk($sformatf("vec%0d_valid", i), 32'(f_valid), 32'(tbl[i].valid));
            chk($sformatf("vec%0d_instr", i), f_instr, tbl[i].instr);
            if (tbl[i].valid) begin
                chk($sformatf("vec%0d_pc", i), f_pc, tbl[i].pc);
                chk($sformatf("vec%0d_pc4", i), f_pcplus4, tbl[i].pc + 32'd4);
            end
            tick();
        end

        // Stall holding a buffered instruction
        set(0, 0, 0, 1, 1, 32'h0040_0213);
        tick();
        set(0, 1, 32'h10, 1, 0, 0);
        chk("stl_redir_req", 32'(imem_req), 32'h0);
        tick();
        set(0, 0, 0, 1, 0, 0);
        chk("stl_req10", 32'(imem_req), 32'h1);
        chk("stl_addr10", imem_addr, 32'h10);
        tick();
        set(1, 0, 0, 1, 1, 32'h0050_0093);
        tick();
        for (int k = 0; k < 3; k++) begin
            set(1, 0, 0, 1, 0, 0);
            chk("stl_req", 32'(imem_req), 32'h0);
            chk("stl_valid", 32'(f_valid), 32'h1);
            chk("stl_instr", f_instr, 32'h0050_0093);
            chk("stl_pc", f_pc, 32'h10);
            chk("stl_pc4", f_pcplus4, 32'h14);
            tick();
        end
        set(0, 0, 0, 1, 0, 0);
        chk("stl_rel_req", 32'(imem_req), 32'h1);
        chk("stl_rel_addr", imem_addr, 32'h14);
        tick();

        // Redirect while waiting: in-flight response dropped
        set(0, 0, 0, 1, 1, 32'hAAAA_0001);
        tick();
        set(0, 1, 32'h40, 1, 0, 0);
        tick();
        set(0, 0, 0, 1, 0, 0);
        chk("rdw_addr40", imem_addr, 32'h40);
        tick();
        set(0, 1, 32'h200, 1, 0, 0);
        chk("rdw_req_wait", 32'(imem_req), 32'h0);
        tick();
        set(0, 0, 0, 1, 1, 32'hBAD0_BAD0);
        chk("rdw_valid", 32'(f_valid), 32'h0);
        chk("rdw_req_drop", 32'(imem_req), 32'h0);
        tick();
        set(0, 0, 0, 1, 0, 0);
        chk("rdw_req200", 32'(imem_req), 32'h1);
        chk("rdw_addr200", imem_addr, 32'h200);
        chk("rdw_valid2", 32'(f_valid), 32'h0);
        tick();
        set(0, 0, 0, 1, 1, 32'h1111_1113);
        tick();
        set(0, 0, 0, 1, 0, 0);
        chk("rdw_fvalid", 32'(f_valid), 32'h1);
        chk("rdw_fpc", f_pc, 32'h200);
        chk("rdw_finstr", f_instr, 32'h1111_1113);

        // Redirect coinciding with a response, unaligned target
        chk("rdv_addr204", imem_addr, 32'h204);
        tick();
        set(0, 1, 32'h103, 1, 1, 32'h2222_2223);
        tick();
        set(0, 0, 0, 1, 0, 0);
        chk("rdv_valid", 32'(f_valid), 32'h0);
        chk("rdv_req", 32'(imem_req), 32'h1);
        chk("rdv_addr", imem_addr, 32'h100);
        tick();

        // Memory not ready for several cycles
        set(0, 0, 0, 1, 1, 32'h3333_3333);
        tick();
        for (int k = 0; k < 5; k++) begin
            set(0, 0, 0, 0, 0, 0);
            chk("nrdy_req", 32'(imem_req), 32'h1);
            chk("nrdy_addr", imem_addr, 32'h104);
            if (k > 0) chk("nrdy_valid", 32'(f_valid), 32'h0);
            tick();
        end
        set(0, 0, 0, 1, 0, 0);
        chk("nrdy_acc_addr", imem_addr, 32'h104);
        tick();
        set(0, 0, 0, 1, 0, 0);
        chk("nrdy_next_addr", imem_addr, 32'h108);
        chk("nrdy_wait_req", 32'(imem_req), 32'h0);

        // Reset while waiting, late response afterwards
        rst = 1'b1;
        tick();
        chk_reset_outs("rstw");
        rst = 1'b0;
        set(0, 0, 0, 1, 1, 32'hDEAD_BEEF);
        chk("late_req", 32'(imem_req), 32'h1);
        chk("late_addr", imem_addr, 32'h0);
        chk("late_instr0", f_instr, NOP);
        tick();
        set(0, 0, 0, 1, 0, 0);
        chk("late_instr1", f_instr, NOP);
        chk("late_valid", 32'(f_valid), 32'h0);
        tick();
        set(0, 0, 0, 1, 1, 32'hCAFE_0013);
        tick();
        set(0, 0, 0, 1, 0, 0);
        chk("late_new_instr", f_instr, 32'hCAFE_0013);
        chk("late_new_pc", f_pc, 32'h0);

        // Random traffic against the reference model
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mem_q.delete();
        mem_on = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            stall       = ($urandom_range(0, 3) == 0);
            redirect    = ($urandom_range(0, 11) == 0);
            redirect_pc = $urandom;
            imem_ready  = ($urandom_range(0, 3) != 0);
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
            rv_from_mem = 1'b0;
            if (mem_q.size() > 0) begin
                if (mem_q[0].wt == 0 && $urandom_range(0, 3) != 0) begin
                    imem_rvalid = 1'b1;
                    rv_from_mem = 1'b1;
                    imem_rdata  = mdata(mem_q[0].addr);
                end
            end else if (m_pend.size() == 0 && $urandom_range(0, 7) == 0) begin
                imem_rvalid = 1'b1;
            end
            #1;
            check_model();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
